// File: rtl/clk_manager.sv
// clk_manager: divides clk_100M into CPU_clk and releases a held CPU reset on a CPU_clk falling edge
module clk_manager #(
  parameter int DIV         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RST_HOLD    = 16
) (
  input  logic clk_100M,
  input  logic res,
  output logic CPU_clk,
  output logic reset
);
  localparam int HALF = DIV / 2;
  localparam int CW   = HALF > 1 ? $clog2(HALF) : 1;
  localparam int HW   = $clog2(RST_HOLD + 1);
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic [HW-1:0]          hold;
  logic                   tog, rise, fall, rel_sync;
  always_comb begin
    tog      = cnt == CW'(HALF - 1);
    rise     = tog & ~CPU_clk;
    fall     = tog & CPU_clk;
    rel_sync = sync[SYNC_STAGES-1];
  end
  always_ff @(posedge clk_100M or negedge res)
    if (!res) begin
      cnt     <= '0;
      CPU_clk <= 1'b0;
    end else begin
      cnt     <= tog ? '0 : cnt + CW'(1);
      CPU_clk <= tog ? ~CPU_clk : CPU_clk;
    end
  always_ff @(posedge clk_100M or negedge res)
    if (!res) sync <= '0;
    else      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  always_ff @(posedge clk_100M or negedge res)
    if (!res)                                 hold <= '0;
    else if (!rel_sync)                       hold <= '0;
    else if (rise && hold != HW'(RST_HOLD))   hold <= hold + HW'(1);
  // hold only advances on rising toggles, so release always lands on a later falling toggle
  always_ff @(posedge clk_100M or negedge res)
    if (!res)                                 reset <= 1'b1;
    else if (fall && hold == HW'(RST_HOLD))   reset <= 1'b0;
endmodule

// File: tb/tb_clk_manager.sv
// tb_clk_manager: four parameterisations checked against an edge-count reference model
module tb_clk_manager;
  logic clk_100M = 1'b0;
  logic res = 1'b0;
  logic [3:0] cpu, rst;
  int vectors = 0, miscompares = 0;
  int n = 0;
  localparam int DV[4] = '{4, 2, 10, 4};
  localparam int SV[4] = '{2, 2, 2, 3};
  localparam int HV[4] = '{16, 16, 16, 1};
  always #5 clk_100M = ~clk_100M;
  clk_manager #(.DIV(4),  .SYNC_STAGES(2), .RST_HOLD(16)) u0 (.clk_100M(clk_100M), .res(res), .CPU_clk(cpu[0]), .reset(rst[0]));
  clk_manager #(.DIV(2),  .SYNC_STAGES(2), .RST_HOLD(16)) u1 (.clk_100M(clk_100M), .res(res), .CPU_clk(cpu[1]), .reset(rst[1]));
  clk_manager #(.DIV(10), .SYNC_STAGES(2), .RST_HOLD(16)) u2 (.clk_100M(clk_100M), .res(res), .CPU_clk(cpu[2]), .reset(rst[2]));
  clk_manager #(.DIV(4),  .SYNC_STAGES(3), .RST_HOLD(1))  u3 (.clk_100M(clk_100M), .res(res), .CPU_clk(cpu[3]), .reset(rst[3]));
  // n = clk_100M edges seen with res high since res last went low
  always @(posedge clk_100M or negedge res)
    if (!res) n <= 0;
    else      n <= n + 1;
  function automatic int rel_edge(int div, int s, int h);
    int half = div / 2;
    int k = 0;
    while (half * (2 * k + 1) < s + 1) k++;
    return half * (2 * k + 1) + 2 * half * (h - 1) + half;
  endfunction
  task automatic check_all(string tag);
    for (int i = 0; i < 4; i++) begin
      logic ec, er;
      ec = ((n / (DV[i] / 2)) % 2) == 1;
      er = n < rel_edge(DV[i], SV[i], HV[i]);
      vectors++;
      assert (cpu[i] === ec) else begin
        miscompares++;
        $error("FAIL %s cpu_clk[%0d] n=%0d observed=%b expected=%b", tag, i, n, cpu[i], ec);
      end
      vectors++;
      assert (rst[i] === er) else begin
        miscompares++;
        $error("FAIL %s reset[%0d] n=%0d observed=%b expected=%b", tag, i, n, rst[i], er);
      end
    end
  endtask
  task automatic run(int cycles, string tag);
    repeat (cycles) begin
      @(negedge clk_100M);
      check_all(tag);
    end
  endtask
  task automatic pulse(int cyc, int off, string tag);
    @(negedge clk_100M);
    #1 res = 1'b0;
    #1 check_all({tag, "_async"});
    repeat (cyc) begin
      @(negedge clk_100M);
      check_all({tag, "_low"});
    end
    #(off) res = 1'b1;
  endtask
  initial begin
    run(20, "power_on");
    #($urandom_range(1, 4)) res = 1'b1;
    run(180, "release");
    pulse(5, 3, "rt_reset");
    run(180, "rerelease");
    pulse(2, 4, "pre_hold");
    run(2 + 8 * 4 + 1, "hold_mid");
    pulse(0, 4, "glitch");
    run(180, "after_glitch");
    for (int r = 0; r < 8; r++) begin
      pulse($urandom_range(0, 6), $urandom_range(3, 4), "rand_pulse");
      run($urandom_range(1, 180), "rand_run");
    end
    run(180, "final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
